// File: rtl/ibfly2_pipe.sv
// Inverse radix-2 butterfly, 3-stage pipeline with valid/ready flow control.
// Optional saturation and sticky ovf port when IBFLY2_SAT_EN is defined.
module ibfly2_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] c,
   input  logic [31:0] ic,
   input  logic [31:0] d,
   input  logic [31:0] id,
   input  logic [31:0] w,
   input  logic [31:0] iw,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] a,
   output logic [31:0] ia,
   output logic [31:0] b,
   output logic [31:0] ib
`ifdef IBFLY2_SAT_EN
   ,
   output logic        ovf
`endif
);

   // Handshake: a pair moves on a rising edge where its valid and the
   // receiver's ready are both high; every stage moves together on advance.
   logic advance;
   assign advance  = !out_valid_q | out_ready;
   assign in_ready = advance;

   logic               v1_q, v2_q, out_valid_q;
   logic signed [32:0] sr1_q, si1_q, dr1_q, di1_q;
   logic signed [31:0] wr1_q, wi1_q;
   logic signed [32:0] ar2_q, ai2_q;
   logic signed [64:0] prr2_q, pii2_q, pir2_q, pri2_q;
   logic        [31:0] a_q, ia_q, b_q, ib_q;

   logic signed [65:0] br_full, bi_full, br_sh, bi_sh, ar_sh, ai_sh;
   logic        [31:0] a_d, ia_d, b_d, ib_d;

   function automatic logic [31:0] reduce32(input logic signed [65:0] x);
`ifdef IBFLY2_SAT_EN
      if (x > 66'sd2147483647)       return 32'h7FFF_FFFF;
      else if (x < -66'sd2147483648) return 32'h8000_0000;
      else                           return x[31:0];
`else
      return x[31:0];
`endif
   endfunction

`ifdef IBFLY2_SAT_EN
   function automatic logic out_of_range(input logic signed [65:0] x);
      return (x > 66'sd2147483647) || (x < -66'sd2147483648);
   endfunction

   logic ovf_pend_q, ovf_pend_d, ovf_q;
   assign ovf = ovf_q;
`endif

   // Bits [16:0] of each product sum are the dropped fraction plus the /2.
   always_comb begin
      br_full = 66'(prr2_q) + 66'(pii2_q);
      bi_full = 66'(pir2_q) - 66'(pri2_q);
      br_sh   = br_full >>> 17;
      bi_sh   = bi_full >>> 17;
      ar_sh   = 66'(ar2_q) >>> 1;
      ai_sh   = 66'(ai2_q) >>> 1;
      a_d     = reduce32(ar_sh);
      ia_d    = reduce32(ai_sh);
      b_d     = reduce32(br_sh);
      ib_d    = reduce32(bi_sh);
`ifdef IBFLY2_SAT_EN
      ovf_pend_d = out_of_range(ar_sh) | out_of_range(ai_sh)
                 | out_of_range(br_sh) | out_of_range(bi_sh);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         sr1_q  <= '0; si1_q  <= '0; dr1_q  <= '0; di1_q  <= '0;
         wr1_q  <= '0; wi1_q  <= '0;
         ar2_q  <= '0; ai2_q  <= '0;
         prr2_q <= '0; pii2_q <= '0; pir2_q <= '0; pri2_q <= '0;
         a_q    <= '0; ia_q   <= '0; b_q    <= '0; ib_q   <= '0;
`ifdef IBFLY2_SAT_EN
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
`ifdef IBFLY2_SAT_EN
         if (out_valid_q && out_ready && ovf_pend_q) ovf_q <= 1'b1;
`endif
         if (advance) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            sr1_q  <= 33'($signed(c))  + 33'($signed(d));
            si1_q  <= 33'($signed(ic)) + 33'($signed(id));
            dr1_q  <= 33'($signed(c))  - 33'($signed(d));
            di1_q  <= 33'($signed(ic)) - 33'($signed(id));
            wr1_q  <= $signed(w);
            wi1_q  <= $signed(iw);
            ar2_q  <= sr1_q;
            ai2_q  <= si1_q;
            prr2_q <= dr1_q * wr1_q;
            pii2_q <= di1_q * wi1_q;
            pir2_q <= di1_q * wr1_q;
            pri2_q <= dr1_q * wi1_q;
            a_q    <= a_d;
            ia_q   <= ia_d;
            b_q    <= b_d;
            ib_q   <= ib_d;
`ifdef IBFLY2_SAT_EN
            ovf_pend_q <= ovf_pend_d;
`endif
         end
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign ia        = ia_q;
   assign b         = b_q;
   assign ib        = ib_q;

endmodule

// File: tb/tb_ibfly2_pipe.sv
// Scoreboard bench for ibfly2_pipe: directed vectors, back-pressure, reset
// flush and randomized traffic against an arithmetic reference model.
module tb_ibfly2_pipe;

   localparam int W = 129;  // {ovf_flag, a, ia, b, ib}

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] c, ic, d, id, w, iw;
   logic [31:0] a, ia, b, ib;
`ifdef IBFLY2_SAT_EN
   logic        ovf;
`endif

   ibfly2_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .c(c), .ic(ic), .d(d), .id(id), .w(w), .iw(iw),
      .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .ia(ia), .b(b), .ib(ib)
`ifdef IBFLY2_SAT_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   logic [W-1:0] exp_q[$];
   logic exp_ovf   = 1'b0;
   logic rand_mode = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic signed [127:0] floordiv(input logic signed [127:0] x,
                                                    input logic signed [127:0] n);
      logic signed [127:0] q;
      q = x / n;
      if (x < 0 && q * n != x) q = q - 1;
      return q;
   endfunction

   function automatic logic [32:0] fit32(input logic signed [127:0] x);
      logic signed [127:0] maxv, minv;
      maxv = 2147483647;
      minv = -maxv - 1;
`ifdef IBFLY2_SAT_EN
      if (x > maxv) return {1'b1, 32'h7FFF_FFFF};
      if (x < minv) return {1'b1, 32'h8000_0000};
      return {1'b0, x[31:0]};
`else
      return {(x > maxv) || (x < minv), x[31:0]};
`endif
   endfunction

   function automatic logic [W-1:0] model(input logic signed [31:0] mc, mic, md, mid, mw, miw);
      logic signed [127:0] dr, di;
      logic [32:0] ra, rai, rb, rbi;
      dr  = mc - md;
      di  = mic - mid;
      ra  = fit32(floordiv(mc + md, 2));
      rai = fit32(floordiv(mic + mid, 2));
      // B = conj(W) * (X0 - X1) / 2, Q16.16 scaling folded into 2^17
      rb  = fit32(floordiv(dr * mw + di * miw, 131072));
      rbi = fit32(floordiv(di * mw - dr * miw, 131072));
      return {ra[32] | rai[32] | rb[32] | rbi[32], ra[31:0], rai[31:0], rb[31:0], rbi[31:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic align();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) align();
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] tc, tic, td, tid, tw, tiw,
                       input logic use_exp, input logic [W-1:0] given);
      int   n;
      logic acc;
      c = tc; ic = tic; d = td; id = tid; w = tw; iw = tiw;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(use_exp ? given : model(tc, tic, td, tid, tw, tiw));
         align();
         if (acc) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 128'(acc), 128'(1'b1));
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         align();
         n++;
      end
      check("drain_timeout", 128'(n < 200), 128'(1'b1));
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
`ifdef IBFLY2_SAT_EN
            check("ovf_sticky", 128'(ovf), 128'(exp_ovf));
`endif
            if (out_valid && !out_ready) check("stall_in_ready", 128'(in_ready), 128'(1'b0));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", {a, ia, b, ib}, 128'hx);
               end else begin
                  e = exp_q.pop_front();
                  check("out_pair", {a, ia, b, ib}, e[127:0]);
                  exp_ovf = exp_ovf | e[128];
                  n_out++;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int base;
      logic [W-1:0] e;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      c = '0; ic = '0; d = '0; id = '0; w = '0; iw = '0;
      #3;
      check("reset_out_valid", 128'(out_valid), 128'(1'b0));
      check("reset_in_ready", 128'(in_ready), 128'(1'b1));
      repeat (2) @(negedge clk);
      check("reset_data", {a, ia, b, ib}, 128'h0);
`ifdef IBFLY2_SAT_EN
      check("reset_ovf", 128'(ovf), 128'(1'b0));
`endif
      rst_n = 1'b1;
      align();

      // Directed vector 1 with exact 3-cycle latency
      send(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1,
           {1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'hFFFF_8000});
      in_valid = 1'b0;
      @(negedge clk); check("latency_c1", 128'(out_valid), 128'(1'b0));
      @(negedge clk); check("latency_c2", 128'(out_valid), 128'(1'b0));
      @(negedge clk); check("latency_c3", 128'(out_valid), 128'(1'b1));
      align();

      send(32'h0002_0000, 32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 1'b1,
           {1'b0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0001_0000});
      send(32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 32'hFFFF_0000, 1'b1,
           {1'b0, 32'h0, 32'h0, 32'h0, 32'h0001_0000});
      drain();
`ifdef IBFLY2_SAT_EN
      check("ovf_before", 128'(ovf), 128'(1'b0));
      send(32'h4000_0000, 32'h0, 32'hC000_0000, 32'h0, 32'h0002_0000, 32'h0, 1'b1,
           {1'b1, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h0});
      drain();
      check("ovf_after", 128'(ovf), 128'(1'b1));
`else
      send(32'h4000_0000, 32'h0, 32'hC000_0000, 32'h0, 32'h0002_0000, 32'h0, 1'b1,
           {1'b1, 32'h0, 32'h0, 32'h8000_0000, 32'h0});
      drain();
`endif

      // Back-pressure: 8 back-to-back pairs, out_ready low in cycles 4-6
      base = n_out;
      fork
         for (int i = 0; i < 8; i++)
            send($urandom, $urandom, $urandom, $urandom,
                 32'($urandom_range(0, 32'h3FFFF)), 32'($urandom_range(0, 32'h3FFFF)), 1'b0, '0);
         begin
            repeat (3) align();
            out_ready = 1'b0;
            repeat (3) align();
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 128'(n_out - base), 128'(8));

      // Reset with two pairs in flight, the first stalled at the output
      out_ready = 1'b0;
      send(32'h0003_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0, '0);
      send(32'h0005_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 1'b0, '0);
      in_valid = 1'b0;
      repeat (2) align();
      check("stalled_valid", 128'(out_valid), 128'(1'b1));
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(1'b0));
      check("rst_in_ready", 128'(in_ready), 128'(1'b1));
      check("rst_data", {a, ia, b, ib}, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("no_stale_pair", 128'(out_valid), 128'(1'b0));
      align();
      send(32'h0002_0000, 32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0001_0000, 32'h0, 1'b1,
           {1'b0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0001_0000});
      drain();

      // Randomized traffic with random back-pressure and input gaps
      base = n_out;
      rand_mode = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (i % 2 == 0)
            send($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0, '0);
         else
            send(32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000,
                 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000,
                 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000,
                 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000,
                 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000,
                 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000, 1'b0, '0);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      in_valid = 1'b0;
      rand_mode = 1'b0;
      align();
      align();
      out_ready = 1'b1;
      drain();
      check("rand_count", 128'(n_out - base), 128'(80));
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
